// File: rtl/e1ofn_pkg.sv
// -----------------------------------------------------------------------------
// e1ofn_pkg
// Shared types and helpers for the e1ofN <-> valid/ready bridge.
//   bits_per_digit : encoded bits needed for one N-rail digit ($clog2(N))
//   rcv_state_t    : receive-half handshake states
//   snd_state_t    : send-half handshake states
//   onehot_valid   : exactly one rail of a digit is high
//   onehot_decode  : index of the high rail of a valid digit
//   onehot_encode  : value -> one-hot rails, saturating to the top rail
// Digit helpers work on a MAX_N-wide rail vector; callers zero-extend their
// N-rail digit into it and truncate results back to N rails.
// -----------------------------------------------------------------------------
package e1ofn_pkg;

    localparam int MAX_N = 16;

    typedef enum logic {
        R_WAIT = 1'b0,
        R_ACK  = 1'b1
    } rcv_state_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DATA    = 2'd1,
        S_NEUTRAL = 2'd2
    } snd_state_t;

    function automatic int bits_per_digit(input int n);
        return $clog2(n);
    endfunction

    // Two or more high rails is an illegal code and never counts as valid.
    function automatic logic onehot_valid(input logic [MAX_N-1:0] rails);
        int cnt;
        cnt = 32'sd0;
        for (int j = 0; j < MAX_N; j++) begin
            if (rails[j]) begin
                cnt = cnt + 32'sd1;
            end else begin
                cnt = cnt;
            end
        end
        return (cnt == 32'sd1);
    endfunction

    function automatic int onehot_decode(input logic [MAX_N-1:0] rails);
        int idx;
        idx = 32'sd0;
        for (int j = 0; j < MAX_N; j++) begin
            if (rails[j]) begin
                idx = j;
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Values that do not fit the digit's rail count land on rail n-1.
    function automatic logic [MAX_N-1:0] onehot_encode(input int value, input int n);
        logic [MAX_N-1:0] rails;
        int               sel;
        sel   = (value >= n) ? (n - 32'sd1) : value;
        rails = '0;
        for (int j = 0; j < MAX_N; j++) begin
            rails[j] = (j == sel);
        end
        return rails;
    endfunction

endpackage

// File: rtl/e1ofn_rtl_bridge_if.sv
// -----------------------------------------------------------------------------
// e1ofn_rtl_bridge_if
// Bundles the asynchronous e1ofN rails and the synchronous valid/ready ports
// of one bridge.
//   in_d/in_e                   : e1ofN receive channel (rails in, enable out)
//   rcv_data/rcv_valid/rcv_ready: decoded tokens towards the RTL body
//   snd_data/snd_valid/snd_ready: tokens from the RTL body
//   out_d/out_e                 : e1ofN send channel (rails out, enable in)
// Modport slave is the bridge's view, master is the surrounding wrapper's.
// -----------------------------------------------------------------------------
interface e1ofn_rtl_bridge_if
    import e1ofn_pkg::*;
#(
    parameter int M = 9,
    parameter int N = 2
);
    localparam int LB = bits_per_digit(N);
    localparam int W  = M * LB;

    logic [M*N-1:0] in_d;
    logic           in_e;
    logic [W-1:0]   rcv_data;
    logic           rcv_valid;
    logic           rcv_ready;
    logic [W-1:0]   snd_data;
    logic           snd_valid;
    logic           snd_ready;
    logic [M*N-1:0] out_d;
    logic           out_e;

    modport slave (
        input  in_d, rcv_ready, snd_data, snd_valid, out_e,
        output in_e, rcv_data, rcv_valid, snd_ready, out_d
    );

    modport master (
        output in_d, rcv_ready, snd_data, snd_valid, out_e,
        input  in_e, rcv_data, rcv_valid, snd_ready, out_d
    );

endinterface

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for asynchronous level inputs.
//   CLK    : destination clock
//   _RESET : async active-low reset, clears both stages
//   d      : asynchronous input bus (WIDTH bits)
//   q      : synchronized output, two CLK edges behind d
// Each bit is synchronized independently; multi-bit coherence is left to the
// caller's protocol (e1ofN rails are qualified by the completion check).
// -----------------------------------------------------------------------------
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             CLK,
    input  logic             _RESET,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            meta_r <= '0;
            sync_r <= '0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/e1ofn_rtl_bridge.sv
// -----------------------------------------------------------------------------
// e1ofn_rtl_bridge
// Clocked bridge between delay-insensitive e1ofN channels (M digits of N
// one-hot rails plus an active-high enable) and synchronous valid/ready ports.
//   CLK    : clock
//   _RESET : async active-low reset
//   bus    : e1ofn_rtl_bridge_if.slave
//            receive half: in_d -> rcv_data/rcv_valid, in_e acks upstream
//            send half   : snd_data/snd_valid -> out_d, paced by out_e
// Digit i rail j is rail bit i*N+j; digit i occupies data bits [i*LB +: LB].
// The two halves share only the clock and reset.
// -----------------------------------------------------------------------------
module e1ofn_rtl_bridge
    import e1ofn_pkg::*;
#(
    parameter int M = 9,
    parameter int N = 2
) (
    input  logic               CLK,
    input  logic               _RESET,
    e1ofn_rtl_bridge_if.slave  bus
);

    localparam int LB = bits_per_digit(N);
    localparam int W  = M * LB;

    logic [M*N-1:0] in_sync_s;
    logic           out_e_sync_s;

    sync2 #(.WIDTH(M*N)) u_sync_in_d (
        .CLK    (CLK),
        ._RESET (_RESET),
        .d      (bus.in_d),
        .q      (in_sync_s)
    );

    sync2 #(.WIDTH(1)) u_sync_out_e (
        .CLK    (CLK),
        ._RESET (_RESET),
        .d      (bus.out_e),
        .q      (out_e_sync_s)
    );

    // ------------------------------------------------------------------
    // Receive half
    // ------------------------------------------------------------------
    rcv_state_t   rcv_state_r;
    rcv_state_t   rcv_state_s;
    logic         capture_s;
    logic         all_valid_s;
    logic         all_neutral_s;
    logic [W-1:0] decoded_s;
    logic         in_e_r;
    logic         rcv_valid_r;
    logic [W-1:0] rcv_data_r;

    // Completion detection and decode of the synchronized incoming rails.
    always_comb begin
        all_valid_s   = 1'b1;
        decoded_s     = '0;
        all_neutral_s = (in_sync_s == '0);
        for (int i = 0; i < M; i++) begin
            all_valid_s = all_valid_s & onehot_valid(MAX_N'(in_sync_s[i*N +: N]));
            decoded_s[i*LB +: LB] = LB'(onehot_decode(MAX_N'(in_sync_s[i*N +: N])));
        end
    end

    // Receive FSM next state; a token is only taken while the output slot is empty.
    always_comb begin
        rcv_state_s = rcv_state_r;
        capture_s   = 1'b0;
        case (rcv_state_r)
            R_WAIT: begin
                if (all_valid_s && !rcv_valid_r) begin
                    rcv_state_s = R_ACK;
                    capture_s   = 1'b1;
                end else begin
                    rcv_state_s = R_WAIT;
                end
            end
            R_ACK: begin
                if (all_neutral_s) begin
                    rcv_state_s = R_WAIT;
                end else begin
                    rcv_state_s = R_ACK;
                end
            end
            default: begin
                rcv_state_s = R_WAIT;
            end
        endcase
    end

    // Receive state, enable and token registers.
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            rcv_state_r <= R_WAIT;
            in_e_r      <= 1'b1;
            rcv_valid_r <= 1'b0;
            rcv_data_r  <= '0;
        end else begin
            rcv_state_r <= rcv_state_s;
            in_e_r      <= (rcv_state_s == R_WAIT);
            if (capture_s) begin
                rcv_data_r  <= decoded_s;
                rcv_valid_r <= 1'b1;
            end else if (rcv_valid_r && bus.rcv_ready) begin
                rcv_valid_r <= 1'b0;
            end else begin
                rcv_valid_r <= rcv_valid_r;
            end
        end
    end

    assign bus.in_e      = in_e_r;
    assign bus.rcv_valid = rcv_valid_r;
    assign bus.rcv_data  = rcv_data_r;

    // ------------------------------------------------------------------
    // Send half
    // ------------------------------------------------------------------
    snd_state_t     snd_state_r;
    snd_state_t     snd_state_s;
    logic           accept_s;
    logic           snd_ready_s;
    logic [M*N-1:0] encoded_s;
    logic [M*N-1:0] out_d_r;

    // snd_ready is decoded from registered state and the synchronized enable
    // so it can rise two edges after reset release, without another flop.
    assign snd_ready_s = (snd_state_r == S_IDLE) && out_e_sync_s;

    // One-hot encode of the offered token, digit by digit.
    always_comb begin
        encoded_s = '0;
        for (int i = 0; i < M; i++) begin
            encoded_s[i*N +: N] = N'(onehot_encode(32'(bus.snd_data[i*LB +: LB]), N));
        end
    end

    // Send FSM next state.
    always_comb begin
        snd_state_s = snd_state_r;
        accept_s    = 1'b0;
        case (snd_state_r)
            S_IDLE: begin
                if (bus.snd_valid && snd_ready_s) begin
                    snd_state_s = S_DATA;
                    accept_s    = 1'b1;
                end else begin
                    snd_state_s = S_IDLE;
                end
            end
            S_DATA: begin
                if (!out_e_sync_s) begin
                    snd_state_s = S_NEUTRAL;
                end else begin
                    snd_state_s = S_DATA;
                end
            end
            S_NEUTRAL: begin
                if (out_e_sync_s) begin
                    snd_state_s = S_IDLE;
                end else begin
                    snd_state_s = S_NEUTRAL;
                end
            end
            default: begin
                snd_state_s = S_IDLE;
            end
        endcase
    end

    // Send state and outgoing rails; rails are only non-zero while in S_DATA.
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            snd_state_r <= S_IDLE;
            out_d_r     <= '0;
        end else begin
            snd_state_r <= snd_state_s;
            if (accept_s) begin
                out_d_r <= encoded_s;
            end else if (snd_state_s == S_DATA) begin
                out_d_r <= out_d_r;
            end else begin
                out_d_r <= '0;
            end
        end
    end

    assign bus.snd_ready = snd_ready_s;
    assign bus.out_d     = out_d_r;

endmodule

// File: tb/tb_e1ofn_rtl_bridge.sv
// -----------------------------------------------------------------------------
// tb_e1ofn_rtl_bridge
// Directed bench for two bridge instances: the 9x2 flit channel (dut_a) and a
// 1x4 channel (dut_b). Expected tokens and rail patterns go into scoreboard
// queues when stimulus is driven and are popped when the DUT presents them.
// -----------------------------------------------------------------------------
module tb_e1ofn_rtl_bridge;

    logic CLK = 1'b0;
    logic _RESET;

    always #5 CLK = ~CLK;

    e1ofn_rtl_bridge_if #(.M(9), .N(2)) ifa ();
    e1ofn_rtl_bridge_if #(.M(1), .N(4)) ifb ();

    e1ofn_rtl_bridge #(.M(9), .N(2)) dut_a (
        .CLK    (CLK),
        ._RESET (_RESET),
        .bus    (ifa)
    );

    e1ofn_rtl_bridge #(.M(1), .N(4)) dut_b (
        .CLK    (CLK),
        ._RESET (_RESET),
        .bus    (ifb)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [63:0] rx_q[$];
    logic [63:0] tx_q[$];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_rx(input string tag, input logic [63:0] obs);
        logic [63:0] exp;
        n_checks++;
        assert (rx_q.size() != 0) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected <empty rx scoreboard>", tag, obs);
        end
        if (rx_q.size() != 0) begin
            exp = rx_q.pop_front();
            check(tag, obs, exp);
        end
    endtask

    task automatic sb_tx(input string tag, input logic [63:0] obs);
        logic [63:0] exp;
        n_checks++;
        assert (tx_q.size() != 0) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected <empty tx scoreboard>", tag, obs);
        end
        if (tx_q.size() != 0) begin
            exp = tx_q.pop_front();
            check(tag, obs, exp);
        end
    endtask

    // 9x2 channel: digit i raises rail 1 when bit i is set, rail 0 otherwise.
    function automatic logic [17:0] rails9(input logic [8:0] v);
        logic [17:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) begin
            r[i*2+1] = v[i];
            r[i*2]   = ~v[i];
        end
        return r;
    endfunction

    initial begin
        _RESET        = 1'b0;
        ifa.in_d      = '0;
        ifa.rcv_ready = 1'b0;
        ifa.snd_data  = '0;
        ifa.snd_valid = 1'b0;
        ifa.out_e     = 1'b1;
        ifb.in_d      = '0;
        ifb.rcv_ready = 1'b0;
        ifb.snd_data  = '0;
        ifb.snd_valid = 1'b0;
        ifb.out_e     = 1'b1;

        // Reset held
        repeat (3) tick();
        check("rst_in_e",      64'(ifa.in_e),      64'd1);
        check("rst_out_d",     64'(ifa.out_d),     64'd0);
        check("rst_rcv_valid", 64'(ifa.rcv_valid), 64'd0);
        check("rst_rcv_data",  64'(ifa.rcv_data),  64'd0);
        check("rst_snd_ready", 64'(ifa.snd_ready), 64'd0);

        // Release; snd_ready within 2 cycles
        _RESET = 1'b1;
        for (int k = 0; k < 2 && ifa.snd_ready !== 1'b1; k++) tick();
        check("rel_snd_ready_a", 64'(ifa.snd_ready), 64'd1);
        check("rel_snd_ready_b", 64'(ifb.snd_ready), 64'd1);

        // Receive 0x1A5 with exact 3-edge latency
        rx_q.push_back(64'h1A5);
        ifa.in_d = rails9(9'h1A5);
        tick();
        tick();
        check("rx1_early_valid", 64'(ifa.rcv_valid), 64'd0);
        check("rx1_early_in_e",  64'(ifa.in_e),      64'd1);
        tick();
        check("rx1_valid", 64'(ifa.rcv_valid), 64'd1);
        check("rx1_in_e",  64'(ifa.in_e),      64'd0);
        sb_rx("rx1_data", 64'(ifa.rcv_data));

        // Neutral phase: in_e back on the 3rd edge
        ifa.in_d = '0;
        tick();
        tick();
        check("neu_early_in_e", 64'(ifa.in_e), 64'd0);
        tick();
        check("neu_in_e", 64'(ifa.in_e), 64'd1);

        // Back-pressure: second token while rcv_valid still high
        rx_q.push_back(64'h0F0);
        ifa.in_d = rails9(9'h0F0);
        repeat (5) tick();
        check("bp_in_e",      64'(ifa.in_e),      64'd1);
        check("bp_rcv_valid", 64'(ifa.rcv_valid), 64'd1);
        check("bp_rcv_data",  64'(ifa.rcv_data),  64'h1A5);

        // Consume first token; the stalled one is taken next
        ifa.rcv_ready = 1'b1;
        tick();
        ifa.rcv_ready = 1'b0;
        check("consume1_valid", 64'(ifa.rcv_valid), 64'd0);
        for (int k = 0; k < 6 && ifa.rcv_valid !== 1'b1; k++) tick();
        check("rx2_valid", 64'(ifa.rcv_valid), 64'd1);
        check("rx2_in_e",  64'(ifa.in_e),      64'd0);
        sb_rx("rx2_data", 64'(ifa.rcv_data));
        ifa.in_d = '0;
        for (int k = 0; k < 6 && ifa.in_e !== 1'b1; k++) tick();
        check("rx2_neu_in_e", 64'(ifa.in_e), 64'd1);
        ifa.rcv_ready = 1'b1;
        tick();
        ifa.rcv_ready = 1'b0;
        check("consume2_valid", 64'(ifa.rcv_valid), 64'd0);

        // Send 0x155
        tx_q.push_back(64'(rails9(9'h155)));
        ifa.snd_data  = 9'h155;
        ifa.snd_valid = 1'b1;
        tick();
        ifa.snd_valid = 1'b0;
        sb_tx("tx1_out_d", 64'(ifa.out_d));
        check("tx1_snd_ready", 64'(ifa.snd_ready), 64'd0);
        ifa.out_e = 1'b0;
        tick();
        tick();
        check("tx1_hold_out_d", 64'(ifa.out_d), 64'(rails9(9'h155)));
        tick();
        check("tx1_neu_out_d", 64'(ifa.out_d), 64'd0);
        ifa.out_e = 1'b1;
        tick();
        tick();
        check("tx1_early_ready", 64'(ifa.snd_ready), 64'd0);
        tick();
        check("tx1_ready", 64'(ifa.snd_ready), 64'd1);

        // 1x4 channel: send value 3
        tx_q.push_back(64'h8);
        ifb.snd_data  = 2'd3;
        ifb.snd_valid = 1'b1;
        tick();
        ifb.snd_valid = 1'b0;
        sb_tx("b_tx_out_d", 64'(ifb.out_d));
        ifb.out_e = 1'b0;
        repeat (3) tick();
        check("b_tx_neu_out_d", 64'(ifb.out_d), 64'd0);
        ifb.out_e = 1'b1;
        repeat (3) tick();
        check("b_tx_ready", 64'(ifb.snd_ready), 64'd1);

        // 1x4 channel: receive rail 1
        rx_q.push_back(64'd1);
        ifb.in_d = 4'b0010;
        repeat (3) tick();
        check("b_rx_valid", 64'(ifb.rcv_valid), 64'd1);
        sb_rx("b_rx_data", 64'(ifb.rcv_data));
        ifb.in_d = '0;
        repeat (3) tick();
        ifb.rcv_ready = 1'b1;
        tick();
        ifb.rcv_ready = 1'b0;

        // 1x4 channel: two rails high is never complete
        ifb.in_d = 4'b0110;
        repeat (5) tick();
        check("b_bad_valid", 64'(ifb.rcv_valid), 64'd0);
        check("b_bad_in_e",  64'(ifb.in_e),      64'd1);
        ifb.in_d = '0;

        // Reset in the middle of S_DATA and R_ACK
        tx_q.push_back(64'(rails9(9'h0AA)));
        ifa.snd_data  = 9'h0AA;
        ifa.snd_valid = 1'b1;
        tick();
        ifa.snd_valid = 1'b0;
        sb_tx("tx2_out_d", 64'(ifa.out_d));
        rx_q.push_back(64'h003);
        ifa.in_d = rails9(9'h003);
        repeat (3) tick();
        check("rx3_in_e", 64'(ifa.in_e), 64'd0);
        sb_rx("rx3_data", 64'(ifa.rcv_data));
        _RESET = 1'b0;
        #2;
        check("arst_out_d",     64'(ifa.out_d),     64'd0);
        check("arst_in_e",      64'(ifa.in_e),      64'd1);
        check("arst_rcv_valid", 64'(ifa.rcv_valid), 64'd0);
        check("arst_snd_ready", 64'(ifa.snd_ready), 64'd0);

        check("rx_q_empty", 64'(rx_q.size()), 64'd0);
        check("tx_q_empty", 64'(tx_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
